// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, port ids, request bundle.
// Default watchdog limits live here so the top and the watchdog agree.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rd;
        logic        wr;
    } req_t;

    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_CNT_W          = 7;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-port, D-port and backend signals around the arbiter.
// slave is the arbiter's view; master is the view of the clients and backend.
interface mem_arbiter_if;

    logic [15:0] i_addr;
    logic [15:0] i_data_in;
    logic        i_rd;
    logic        i_wr;
    logic [15:0] i_data_out;
    logic        i_done;
    logic        i_stall;
    logic        i_hit;
    logic        i_err;

    logic [15:0] d_addr;
    logic [15:0] d_data_in;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_data_out;
    logic        d_done;
    logic        d_stall;
    logic        d_hit;
    logic        d_err;

    logic [15:0] m_addr;
    logic [15:0] m_data_in;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_data_out;
    logic        m_done;
    logic        m_stall;
    logic        m_hit;
    logic        m_err;

    modport slave (
        input  i_addr, i_data_in, i_rd, i_wr,
        output i_data_out, i_done, i_stall, i_hit, i_err,
        input  d_addr, d_data_in, d_rd, d_wr,
        output d_data_out, d_done, d_stall, d_hit, d_err,
        output m_addr, m_data_in, m_rd, m_wr,
        input  m_data_out, m_done, m_stall, m_hit, m_err
    );

    modport master (
        output i_addr, i_data_in, i_rd, i_wr,
        input  i_data_out, i_done, i_stall, i_hit, i_err,
        output d_addr, d_data_in, d_rd, d_wr,
        input  d_data_out, d_done, d_stall, d_hit, d_err,
        input  m_addr, m_data_in, m_rd, m_wr,
        output m_data_out, m_done, m_stall, m_hit, m_err
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: load to 1 on grant, count busy cycles, saturate at the limit.
// expired is combinational from the count; no backpressure.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin I/D arbiter in front of mem_system; grant drives the backend in the same cycle.
// Losing and owning ports see stall until done; one idle gap separates backend transactions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t state;
    port_t  last_grant;
    req_t   latch;
    logic   gap;

    req_t i_req, d_req, drive;
    logic i_any, d_any, i_ill, d_ill, i_ok, d_ok;
    logic arb, grant_i, grant_d, busy_i, busy_d, busy;
    logic expired, fin;

    assign i_req = '{addr: bus.i_addr, data: bus.i_data_in, rd: bus.i_rd, wr: bus.i_wr};
    assign d_req = '{addr: bus.d_addr, data: bus.d_data_in, rd: bus.d_rd, wr: bus.d_wr};

    assign i_any = bus.i_rd | bus.i_wr;
    assign d_any = bus.d_rd | bus.d_wr;
    assign i_ill = bus.i_rd & bus.i_wr;
    assign d_ill = bus.d_rd & bus.d_wr;
    assign i_ok  = i_any & ~i_ill;
    assign d_ok  = d_any & ~d_ill;

    // The idle cycle right after a completion is a forced gap: no grant, no error pulses.
    assign arb     = (state == IDLE) & ~gap;
    assign grant_i = arb & i_ok & (~d_ok | (last_grant == PORT_D));
    assign grant_d = arb & d_ok & (~i_ok | (last_grant == PORT_I));
    assign busy_i  = (state == BUSY_I);
    assign busy_d  = (state == BUSY_D);
    assign busy    = busy_i | busy_d;
    assign fin     = busy & (bus.m_done | expired);

    mem_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .load    (grant_i | grant_d),
        .inc     (busy & ~bus.m_done),
        .expired (expired)
    );

    always_comb begin
        drive          = '0;
        bus.m_addr     = '0;
        bus.m_data_in  = '0;
        bus.m_rd       = 1'b0;
        bus.m_wr       = 1'b0;
        bus.i_done     = 1'b0;
        bus.i_err      = 1'b0;
        bus.i_hit      = 1'b0;
        bus.i_data_out = '0;
        bus.i_stall    = 1'b0;
        bus.d_done     = 1'b0;
        bus.d_err      = 1'b0;
        bus.d_hit      = 1'b0;
        bus.d_data_out = '0;
        bus.d_stall    = 1'b0;
        if (!rst) begin
            if (busy)         drive = latch;
            else if (grant_d) drive = d_req;
            else if (grant_i) drive = i_req;
            bus.m_addr    = drive.addr;
            bus.m_data_in = drive.data;
            bus.m_rd      = drive.rd;
            bus.m_wr      = drive.wr;

            // A real m_done wins over a coincident watchdog expiry.
            bus.i_done     = (busy_i & fin) | (arb & i_ill);
            bus.i_err      = (busy_i & fin & (bus.m_done ? bus.m_err : 1'b1)) | (arb & i_ill);
            bus.i_hit      = busy_i & bus.m_done & bus.m_hit;
            bus.i_data_out = (busy_i & bus.m_done) ? bus.m_data_out : 16'h0000;
            bus.i_stall    = (busy_i | grant_i) ? (bus.m_stall | ~bus.i_done)
                                                : (i_any & ~bus.i_done);

            bus.d_done     = (busy_d & fin) | (arb & d_ill);
            bus.d_err      = (busy_d & fin & (bus.m_done ? bus.m_err : 1'b1)) | (arb & d_ill);
            bus.d_hit      = busy_d & bus.m_done & bus.m_hit;
            bus.d_data_out = (busy_d & bus.m_done) ? bus.m_data_out : 16'h0000;
            bus.d_stall    = (busy_d | grant_d) ? (bus.m_stall | ~bus.d_done)
                                                : (d_any & ~bus.d_done);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_I;
            latch      <= '0;
            gap        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gap <= 1'b0;
                    if (grant_d) begin
                        state      <= BUSY_D;
                        latch      <= d_req;
                        last_grant <= PORT_D;
                    end else if (grant_i) begin
                        state      <= BUSY_I;
                        latch      <= i_req;
                        last_grant <= PORT_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (fin) begin
                        state <= IDLE;
                        gap   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized two-client / random-latency backend run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bif();

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] outs();
        return {6'b0, bif.i_data_out, bif.i_done, bif.i_stall, bif.i_hit, bif.i_err,
                bif.d_data_out, bif.d_done, bif.d_stall, bif.d_hit, bif.d_err,
                bif.m_addr, bif.m_data_in, bif.m_rd, bif.m_wr};
    endfunction

    task automatic idle_in();
        bif.i_addr = '0; bif.i_data_in = '0; bif.i_rd = 1'b0; bif.i_wr = 1'b0;
        bif.d_addr = '0; bif.d_data_in = '0; bif.d_rd = 1'b0; bif.d_wr = 1'b0;
        bif.m_data_out = '0; bif.m_done = 1'b0; bif.m_stall = 1'b0;
        bif.m_hit = 1'b0; bif.m_err = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Randomized-phase model state: pending requests per port (0=I, 1=D) and transaction owner.
    bit          pv [2];
    logic        prd[2], pwr[2];
    logic [15:0] pad[2], pdt[2];
    int          owner, last, age, lat, win;
    bit          gap, fin;
    logic [15:0] t_addr, t_data, rdat, e_addr, e_data;
    logic        t_rd, t_wr, rhit, rerr, stl, e_rd, e_wr;
    logic        ed[2], es[2];

    initial begin
        idle_in();
        rst = 1'b1;
        bif.i_rd = 1'b1; bif.i_addr = 16'h0040;
        #3;
        chk("rst_during", outs(), 80'h0);
        nxt(); #3;
        chk("rst_during2", outs(), 80'h0);
        nxt();
        rst = 1'b0;
        idle_in();
        #3;
        chk("rst_after", outs(), 80'h0);

        // I-port read, backend done on cycle 3
        nxt();
        bif.i_rd = 1'b1; bif.i_addr = 16'h0040;
        #3;
        chk("t1_c0_m", {bif.m_rd, bif.m_wr, bif.m_addr}, {1'b1, 1'b0, 16'h0040});
        chk("t1_c0_st", {bif.i_stall, bif.i_done, bif.d_stall}, 3'b100);
        for (int c = 1; c <= 2; c++) begin
            nxt(); #3;
            chk("t1_busy", {bif.m_rd, bif.m_addr, bif.i_done}, {1'b1, 16'h0040, 1'b0});
        end
        nxt();
        bif.m_done = 1'b1; bif.m_data_out = 16'hBEEF; bif.m_hit = 1'b0;
        #3;
        chk("t1_done", {bif.i_done, bif.i_data_out, bif.i_hit, bif.i_err, bif.m_rd},
                       {1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1});
        nxt();
        idle_in();
        #3;
        chk("t1_gap", {bif.m_rd, bif.m_wr, bif.i_done, bif.i_data_out}, 19'h0);

        // Simultaneous requests after reset: D first, latch holds across d_addr change
        do_reset();
        bif.i_rd = 1'b1; bif.i_addr = 16'h0010;
        bif.d_wr = 1'b1; bif.d_addr = 16'h0020; bif.d_data_in = 16'h1234;
        #3;
        chk("t2_dwin", {bif.m_rd, bif.m_wr, bif.m_addr, bif.m_data_in},
                       {1'b0, 1'b1, 16'h0020, 16'h1234});
        chk("t2_stall", {bif.i_stall, bif.d_stall}, 2'b11);
        nxt();
        bif.d_addr = 16'hFFFF;
        #3;
        chk("t2_latch", {bif.m_wr, bif.m_addr}, {1'b1, 16'h0020});
        nxt();
        bif.m_done = 1'b1; bif.m_data_out = 16'h0000;
        #3;
        chk("t2_ddone", {bif.d_done, bif.i_done, bif.i_stall, bif.m_addr}, {3'b101, 16'h0020});
        nxt();
        bif.m_done = 1'b0; bif.d_wr = 1'b0; bif.d_addr = '0; bif.d_data_in = '0;
        #3;
        chk("t2_gap", {bif.m_rd, bif.m_wr, bif.i_stall, bif.i_done}, 4'b0010);
        nxt(); #3;
        chk("t2_iserve", {bif.m_rd, bif.m_wr, bif.m_addr}, {1'b1, 1'b0, 16'h0010});
        nxt();
        bif.m_done = 1'b1; bif.m_data_out = 16'h5A5A;
        #3;
        chk("t2_idone", {bif.i_done, bif.d_done, bif.i_data_out}, {2'b10, 16'h5A5A});
        nxt();
        idle_in();

        // Round-robin with both ports requesting continuously: D, I, D, I
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bif.i_rd = 1'b1; bif.i_addr = 16'h0100 + 16'(k);
            bif.d_rd = 1'b1; bif.d_addr = 16'h0200 + 16'(k);
            #3;
            chk("rr_grant", bif.m_addr, (k % 2 == 0) ? 16'h0200 + 16'(k) : 16'h0100 + 16'(k));
            nxt();
            bif.m_done = 1'b1; bif.m_data_out = 16'(k);
            #3;
            chk("rr_done", {bif.i_done, bif.d_done}, (k % 2 == 0) ? 2'b01 : 2'b10);
            nxt();
            bif.m_done = 1'b0;
            #3;
            chk("rr_gap", {bif.m_rd, bif.m_wr}, 2'b00);
            nxt();
        end
        idle_in();

        // Watchdog abort after TO busy cycles, then a late m_done is dropped
        bif.i_rd = 1'b1; bif.i_addr = 16'h0300; bif.m_hit = 1'b1;
        #3;
        chk("to_accept", {bif.m_rd, bif.m_addr}, {1'b1, 16'h0300});
        for (int c = 1; c < TO; c++) begin
            nxt(); #3;
            chk("to_wait", {bif.i_done, bif.i_err, bif.m_rd}, 3'b001);
        end
        nxt(); #3;
        chk("to_abort", {bif.i_done, bif.i_err, bif.i_hit, bif.i_data_out, bif.i_stall},
                        {3'b110, 16'h0000, 1'b0});
        nxt();
        idle_in();
        #3;
        chk("to_idle", outs(), 80'h0);
        nxt();
        bif.m_done = 1'b1; bif.m_data_out = 16'hFFFF; bif.m_hit = 1'b1;
        #3;
        chk("to_late", {bif.i_done, bif.d_done, bif.i_data_out, bif.d_data_out, bif.i_hit, bif.d_hit},
                       36'h0);
        nxt();
        idle_in();

        // Illegal rd+wr on D in IDLE
        bif.d_rd = 1'b1; bif.d_wr = 1'b1; bif.d_addr = 16'h0123;
        #3;
        chk("ill", {bif.d_done, bif.d_err, bif.d_hit, bif.m_rd, bif.m_wr, bif.d_stall}, 6'b110000);
        nxt();
        idle_in();
        #3;
        chk("ill_after", outs(), 80'h0);

        // Reset in the middle of an I transaction
        nxt();
        bif.i_rd = 1'b1; bif.i_addr = 16'h0444;
        #3;
        chk("rm_accept", {bif.m_rd, bif.m_addr}, {1'b1, 16'h0444});
        nxt();
        nxt();
        rst = 1'b1; bif.m_done = 1'b1; bif.m_data_out = 16'hAAAA;
        #3;
        chk("rm_during", outs(), 80'h0);
        nxt();
        rst = 1'b0;
        idle_in();
        #3;
        chk("rm_next", outs(), 80'h0);
        nxt(); #3;
        chk("rm_next2", outs(), 80'h0);

        // Randomized traffic against the transaction-level model
        do_reset();
        owner = -1; last = 0; gap = 1'b0; age = 0; lat = 0;
        t_addr = '0; t_data = '0; t_rd = 1'b0; t_wr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; prd[p] = 1'b0; pwr[p] = 1'b0; pad[p] = '0; pdt[p] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(2) == 0) begin
                    pv[p]  = 1'b1;
                    prd[p] = 1'($urandom_range(1));
                    pwr[p] = ~prd[p];
                    pad[p] = 16'($urandom);
                    pdt[p] = 16'($urandom);
                end
            end
            // The owner may wiggle its address/data while busy; the backend must not follow.
            if (owner >= 0 && $urandom_range(1) == 1) begin
                pad[owner] = 16'($urandom);
                pdt[owner] = 16'($urandom);
            end
            bif.i_rd = pv[0] & prd[0]; bif.i_wr = pv[0] & pwr[0];
            bif.i_addr = pad[0]; bif.i_data_in = pdt[0];
            bif.d_rd = pv[1] & prd[1]; bif.d_wr = pv[1] & pwr[1];
            bif.d_addr = pad[1]; bif.d_data_in = pdt[1];

            win = -1;
            if (owner < 0 && !gap) begin
                if (pv[0] && pv[1]) win = 1 - last;
                else if (pv[0])     win = 0;
                else if (pv[1])     win = 1;
            end
            fin  = (owner >= 0) && (age == lat);
            stl  = 1'($urandom_range(1));
            rdat = 16'($urandom);
            rhit = 1'($urandom_range(1));
            rerr = 1'($urandom_range(1));
            bif.m_done = fin; bif.m_stall = stl; bif.m_data_out = rdat;
            bif.m_hit = rhit; bif.m_err = rerr;

            if (owner >= 0) begin
                e_addr = t_addr; e_data = t_data; e_rd = t_rd; e_wr = t_wr;
            end else if (win >= 0) begin
                e_addr = pad[win]; e_data = pdt[win]; e_rd = prd[win]; e_wr = pwr[win];
            end else begin
                e_addr = '0; e_data = '0; e_rd = 1'b0; e_wr = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                ed[p] = fin && (owner == p);
                es[p] = ((owner == p) || (win == p)) ? (stl | ~ed[p]) : (pv[p] & ~ed[p]);
            end

            #3;
            chk("rnd_m", {bif.m_rd, bif.m_wr, bif.m_addr, bif.m_data_in}, {e_rd, e_wr, e_addr, e_data});
            chk("rnd_i", {bif.i_done, bif.i_hit, bif.i_err, bif.i_data_out, bif.i_stall},
                         {ed[0], ed[0] & rhit, ed[0] & rerr, ed[0] ? rdat : 16'h0000, es[0]});
            chk("rnd_d", {bif.d_done, bif.d_hit, bif.d_err, bif.d_data_out, bif.d_stall},
                         {ed[1], ed[1] & rhit, ed[1] & rerr, ed[1] ? rdat : 16'h0000, es[1]});

            if (fin) begin
                pv[owner] = 1'b0;
                owner = -1;
                gap = 1'b1;
            end else if (owner >= 0) begin
                age++;
            end else begin
                gap = 1'b0;
                if (win >= 0) begin
                    owner = win; last = win;
                    t_addr = pad[win]; t_data = pdt[win]; t_rd = prd[win]; t_wr = pwr[win];
                    age = 1;
                    lat = $urandom_range(5, 1);
                end
            end
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
